// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus between the IF fetch engine and IM.
// One request per cycle on req/addr; data returns later on rvalid/rdata.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: one IM read in flight, 1-entry skid buffer,
// MIPS delay-slot redirect handling into the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  if_fetch_unit_if.master         imem,
  output logic                    if_valid,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_instr
);

  logic [31:0] pc_next;
  logic        outst;
  logic        skid_v;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] issue_pc;

  logic        accept;
  logic        ifid_free;
  logic        issue;
  logic [31:0] redir_addr;
  logic [31:0] fetch_addr;

  always_comb begin
    accept     = imem.rvalid && outst;
    ifid_free  = !if_valid || !stall;
    redir_addr = {redirect_pc[31:2], 2'b00};
    fetch_addr = redirect_valid ? redir_addr : pc_next;
    // Never let a second word beyond IF/ID exist: that keeps PC+8
    // from being fetched after a branch.
    issue      = (!outst || accept) && !skid_v
                 && !(accept && !ifid_free) && reset;
    imem.req   = issue;
    imem.addr  = issue ? fetch_addr : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_next    <= RESET_PC;
      outst      <= 1'b0;
      skid_v     <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
      issue_pc   <= 32'h0;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
    end else begin
      if (issue) begin
        issue_pc <= fetch_addr;
        outst    <= 1'b1;
        pc_next  <= fetch_addr + 32'd4;
      end else begin
        if (redirect_valid)
          pc_next <= redir_addr;
        if (accept)
          outst <= 1'b0;
      end

      if (if_valid && stall) begin
        if (accept) begin
          skid_v     <= 1'b1;
          skid_pc    <= issue_pc;
          skid_instr <= imem.rdata;
        end
      end else if (skid_v) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_instr <= skid_instr;
        skid_v   <= 1'b0;
      end else if (accept) begin
        if_valid <= 1'b1;
        if_pc    <= issue_pc;
        if_instr <= imem.rdata;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: 1-cycle IM model echoing the address,
// with a manual rvalid override for the reset-mid-read case.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        mem_auto;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        seen_3010;

  int n_chk;
  int n_fail;

  if_fetch_unit_if imem ();

  assign imem.rvalid = mem_auto ? m_rvalid : man_rvalid;
  assign imem.rdata  = mem_auto ? m_rdata  : man_rdata;

  if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem.master),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_rvalid <= imem.req;
    m_rdata  <= imem.addr;
    if (imem.req && imem.addr == 32'h0000_3010)
      seen_3010 <= 1'b1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_auto       = 1'b1;
    man_rvalid     = 1'b0;
    man_rdata      = 32'h0;
    m_rvalid       = 1'b0;
    m_rdata        = 32'h0;
    seen_3010      = 1'b0;

    // T1: reset held two cycles
    cyc(); #1;
    check("rst_req", {31'h0, imem.req}, 32'h0);
    check("rst_addr", imem.addr, 32'h0);
    cyc(); #1;
    check("rst_ifv", {31'h0, if_valid}, 32'h0);
    check("rst_ifpc", if_pc, 32'h0);
    check("rst_ifinstr", if_instr, 32'h0);
    cyc(); reset = 1'b1; #1;
    check("t1_req", {31'h0, imem.req}, 32'h1);
    check("t1_addr", imem.addr, 32'h3000);
    cyc(); #1;
    check("t1_ifv0", {31'h0, if_valid}, 32'h0);
    check("t2_addr1", imem.addr, 32'h3004);

    // T2: streaming, one word per cycle
    cyc(); #1;
    check("t1_ifv", {31'h0, if_valid}, 32'h1);
    check("t2_pc0", if_pc, 32'h3000);
    check("t2_ins0", if_instr, 32'h3000);
    check("t2_addr2", imem.addr, 32'h3008);
    check("t2_req2", {31'h0, imem.req}, 32'h1);
    cyc(); #1;
    check("t2_pc1", if_pc, 32'h3004);
    check("t2_addr3", imem.addr, 32'h300C);

    // T3: beq at 0x3008 redirects, delay slot 0x300C still delivered
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h3101; #1;
    check("t2_pc2", if_pc, 32'h3008);
    check("t3_addr_tgt", imem.addr, 32'h3100);
    cyc(); redirect_valid = 1'b0; #1;
    check("t3_slot", if_pc, 32'h300C);
    check("t3_addr_nx", imem.addr, 32'h3104);
    cyc(); #1;
    check("t3_tgt", if_pc, 32'h3100);
    check("t3_addr_nx2", imem.addr, 32'h3108);

    // T4: stall 3 cycles with a word in flight
    cyc(); stall = 1'b1; #1;
    check("t4_pc_hold0", if_pc, 32'h3104);
    check("t4_req0", {31'h0, imem.req}, 32'h0);
    cyc(); #1;
    check("t4_req1", {31'h0, imem.req}, 32'h0);
    check("t4_pc_hold1", if_pc, 32'h3104);
    cyc(); #1;
    check("t4_req2", {31'h0, imem.req}, 32'h0);
    cyc(); stall = 1'b0; #1;
    check("t4_req3", {31'h0, imem.req}, 32'h0);
    check("t4_pc_hold3", if_pc, 32'h3104);
    cyc(); #1;
    check("t4_skid_pc", if_pc, 32'h3108);
    check("t4_skid_ins", if_instr, 32'h3108);
    check("t4_reissue", imem.addr, 32'h310C);
    check("t4_reissue_req", {31'h0, imem.req}, 32'h1);
    cyc(); #1;
    check("t4_bubble", {31'h0, if_valid}, 32'h0);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    check("t4_pc_after", if_pc, 32'h310C);

    // T5: wrap at top of address space
    check("t5_addr_top", imem.addr, 32'hFFFF_FFFC);
    cyc(); redirect_valid = 1'b0; #1;
    check("t5_addr_wrap", imem.addr, 32'h0);
    check("t5_pc_prev", if_pc, 32'h3110);
    cyc(); stall = 1'b1; #1;
    check("t5_pc_top", if_pc, 32'hFFFF_FFFC);
    check("t5_stall_req", {31'h0, imem.req}, 32'h0);
    // redirect while skid holds the word fetched from 0x0
    cyc(); stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h4000; #1;
    check("t5_skid_req", {31'h0, imem.req}, 32'h0);
    cyc(); redirect_valid = 1'b0; #1;
    check("t5_drain_pc", if_pc, 32'h0);
    check("t5_tgt_req", {31'h0, imem.req}, 32'h1);
    check("t5_tgt_addr", imem.addr, 32'h4000);
    cyc(); #1;
    check("t5_tgt_next", imem.addr, 32'h4004);
    cyc(); mem_auto = 1'b0; man_rvalid = 1'b0; #1;
    check("t5_tgt_ifpc", if_pc, 32'h4000);
    check("t6_wait_req", {31'h0, imem.req}, 32'h0);

    // T6: reset while 0x4004 is in flight; late rvalid must be dropped
    cyc(); reset = 1'b0; #1;
    check("t6_rst_req", {31'h0, imem.req}, 32'h0);
    check("t6_rst_addr", imem.addr, 32'h0);
    cyc(); reset = 1'b1; man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF; #1;
    check("t6_restart", imem.addr, 32'h3000);
    check("t6_restart_req", {31'h0, imem.req}, 32'h1);
    cyc(); man_rvalid = 1'b0; #1;
    check("t6_dropped", {31'h0, if_valid}, 32'h0);
    check("t6_outst_req", {31'h0, imem.req}, 32'h0);
    cyc(); man_rvalid = 1'b1; man_rdata = 32'h1111_1111; #1;
    check("t6_next_addr", imem.addr, 32'h3004);
    cyc(); man_rvalid = 1'b0; #1;
    check("t6_ifv", {31'h0, if_valid}, 32'h1);
    check("t6_ifpc", if_pc, 32'h3000);
    check("t6_ifinstr", if_instr, 32'h1111_1111);

    check("t3_no_3010", {31'h0, seen_3010}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
